// File: rtl/disp_pkg.sv
// Shared FSM state encodings and active-low 7-segment codes ({g,f,e,d,c,b,a})
// for the counter display driver.
package disp_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = S_IDLE,
    SHIFT = S_SHIFT,
    DONE  = S_DONE
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment decoder; zero latency.
// Codes above 9 and an asserted blank both produce an unlit digit.
module seg7_decode
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/count_display_driver.sv
// Binary-to-BCD (double-dabble) converter feeding a multiplexed 7-seg scan; busy for WIDTH+1 cycles.
// Requests arriving while busy are dropped; the scan free-runs and always shows the committed bcd.
module count_display_driver
  import disp_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      value,
  input  logic                  upd,
  output logic                  busy,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  shreg;
  logic [BW-1:0]     scratch;
  logic [BW-1:0]     adj;
  logic [CW-1:0]     cnt;
  logic [PW-1:0]     presc;
  logic              tick;
  logic [IW-1:0]     dig;
  logic [DIGITS-1:0] blank_vec;
  logic              nz;
  logic [3:0]        nib;
  logic [6:0]        seg_dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (upd) state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign dp   = 1'b1;

  // Add-3 correction is applied before the shift so each nibble stays a legal BCD digit.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (upd) begin
            shreg   <= value;
            scratch <= '0;
            cnt     <= '0;
          end
        end
        SHIFT: begin
          {scratch, shreg} <= {adj, shreg} << 1;
          cnt              <= cnt + 1'b1;
        end
        DONE:    bcd <= scratch;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      tick  <= 1'b0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc <= '0;
      tick  <= 1'b1;
    end else begin
      presc <= presc + 1'b1;
      tick  <= 1'b0;
    end
  end

  // A digit above 0 is blanked only when it and every higher digit are zero.
  always_comb begin
    blank_vec = '0;
    nz        = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      nz           = nz | (bcd[4*i +: 4] != 4'd0);
      blank_vec[i] = !nz;
    end
  end

  assign nib = bcd[{dig, 2'b00} +: 4];

  seg7_decode u_dec (
    .nibble (nib),
    .blank  (blank_vec[dig]),
    .seg    (seg_dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig <= '0;
      an  <= '1;
      seg <= SEG_BLANK;
    end else if (tick) begin
      an  <= ~(DIGITS'(1) << dig);
      seg <= seg_dec;
      dig <= (dig == IW'(DIGITS - 1)) ? '0 : dig + 1'b1;
    end
  end

endmodule

// File: tb/tb_count_display_driver.sv
// Self-checking bench for count_display_driver with a fast scan divider.
module tb_count_display_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd;
  logic [7:0]  value;
  logic        busy;
  logic [11:0] bcd;
  logic [2:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] exp_q[$];

  localparam logic [6:0] B  = 7'h7F;
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;

  typedef struct {
    logic [7:0]  v;
    logic [11:0] e;
  } vec_t;

  vec_t tbl [12];

  always #5 clk = ~clk;

  count_display_driver #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .upd   (upd),
    .busy  (busy),
    .bcd   (bcd),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 50) begin
      step(1);
      g++;
    end
  endtask

  task automatic start_conv(input logic [7:0] v);
    wait_idle();
    value = v;
    upd   = 1'b1;
    step(1);
    upd   = 1'b0;
  endtask

  task automatic do_conv(input string name, input logic [7:0] v, input logic [11:0] e);
    int len = 0;
    exp_q.push_back(e);
    start_conv(v);
    while (busy && len < 40) begin
      len++;
      step(1);
    end
    chk({name, " busy_len"}, len, 9);
    chk({name, " bcd"}, bcd, exp_q.pop_front());
  endtask

  task automatic check_scan(input string name, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2);
    logic [2:0] seen = 3'b000;
    step(5);
    for (int c = 0; c < 40 && seen != 3'b111; c++) begin
      case (an)
        3'b110: if (!seen[0]) begin chk({name, " seg d0"}, seg, s0); seen[0] = 1'b1; end
        3'b101: if (!seen[1]) begin chk({name, " seg d1"}, seg, s1); seen[1] = 1'b1; end
        3'b011: if (!seen[2]) begin chk({name, " seg d2"}, seg, s2); seen[2] = 1'b1; end
        default: ;
      endcase
      step(1);
    end
    chk({name, " all_digits_scanned"}, seen, 3'b111);
    chk({name, " dp"}, dp, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] prev;
    logic [2:0] exp_seq [4];
    int last_t;
    int idx;
    int len;

    tbl[0]  = '{8'd0,   12'h000};
    tbl[1]  = '{8'd1,   12'h001};
    tbl[2]  = '{8'd9,   12'h009};
    tbl[3]  = '{8'd10,  12'h010};
    tbl[4]  = '{8'd99,  12'h099};
    tbl[5]  = '{8'd100, 12'h100};
    tbl[6]  = '{8'd128, 12'h128};
    tbl[7]  = '{8'd199, 12'h199};
    tbl[8]  = '{8'd200, 12'h200};
    tbl[9]  = '{8'd254, 12'h254};
    tbl[10] = '{8'd47,  12'h047};
    tbl[11] = '{8'd63,  12'h063};
    exp_seq = '{3'b110, 3'b101, 3'b011, 3'b110};

    rst = 1'b1; upd = 1'b0; value = 8'd0;
    step(2);
    chk("reset busy", busy, 1'b0);
    chk("reset bcd",  bcd,  12'h000);
    chk("reset an",   an,   3'b111);
    chk("reset seg",  seg,  7'h7F);
    chk("reset dp",   dp,   1'b1);

    // Free-running scan order and slot spacing after reset release
    rst = 1'b0;
    prev = an; last_t = 0; idx = 0;
    for (int t = 1; t <= 30; t++) begin
      step(1);
      if (an !== prev) begin
        if (idx < 4) begin
          chk("scan order", an, exp_seq[idx]);
          if (idx == 0) chk("scan first slot delay", (t >= 4 && t <= 5), 1'b1);
          else          chk("scan slot spacing", t - last_t, 4);
        end
        last_t = t;
        idx++;
        prev = an;
      end
    end
    chk("scan changes seen", (idx >= 4), 1'b1);

    do_conv("v255", 8'd255, 12'h255);
    check_scan("scan255", 7'b0010010, 7'b0010010, S2);

    for (int i = 0; i < 12; i++) begin
      do_conv($sformatf("tbl%0d", i), tbl[i].v, tbl[i].e);
    end

    do_conv("v100", 8'd100, 12'h100);
    check_scan("scan100", S0, S0, S1);

    do_conv("v0", 8'd0, 12'h000);
    check_scan("scan0", S0, B, B);

    // Request while busy is dropped and value change mid-conversion is ignored
    exp_q.push_back(12'h047);
    start_conv(8'd47);
    step(2);
    value = 8'd9; upd = 1'b1;
    step(1);
    upd = 1'b0;
    len = 0;
    while (busy && len < 40) begin len++; step(1); end
    chk("busy-upd bcd", bcd, exp_q.pop_front());
    step(2);
    chk("busy-upd not queued", busy, 1'b0);
    do_conv("v9", 8'd9, 12'h009);
    check_scan("scan9", S9, B, B);

    // Held request retriggers on the first idle cycle
    value = 8'd5; upd = 1'b1;
    step(1);
    len = 0;
    while (busy && len < 40) begin len++; step(1); end
    chk("held upd first bcd", bcd, 12'h005);
    chk("held upd idle gap", busy, 1'b0);
    step(1);
    chk("held upd retrigger", busy, 1'b1);
    upd = 1'b0;
    wait_idle();
    chk("held upd second bcd", bcd, 12'h005);

    // Reset during a conversion while the display is lit
    start_conv(8'd255);
    step(2);
    rst = 1'b1;
    #2;
    chk("midrun rst busy", busy, 1'b0);
    chk("midrun rst bcd",  bcd,  12'h000);
    chk("midrun rst an",   an,   3'b111);
    chk("midrun rst seg",  seg,  7'h7F);
    chk("midrun rst dp",   dp,   1'b1);
    rst = 1'b0;
    step(1);

    // Reset at the fourth shift, then a clean conversion
    do_conv("pre77", 8'd77, 12'h077);
    start_conv(8'd200);
    step(4);
    rst = 1'b1;
    #2;
    chk("shift4 rst busy", busy, 1'b0);
    chk("shift4 rst bcd",  bcd,  12'h000);
    rst = 1'b0;
    step(1);
    do_conv("v128", 8'd128, 12'h128);
    check_scan("scan128", S8, S2, S1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
